// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IE/IF registers, IME with delayed EI,
// fixed-priority arbitration and registered ISR dispatch to the decoder.
module gb_cpu_interrupt_ctrl #(
    parameter int         NUM_IRQ    = 5,
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter int         VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_pulse,
    input  logic               ie_wr,
    input  logic               if_wr,
    input  logic [7:0]         wdata,
    output logic [7:0]         ie_q,
    output logic [7:0]         if_q,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               instr_boundary,
    input  logic               isr_ack,
    output logic               isr_cmd,
    output logic [7:0]         isr_vector,
    output logic               ime_q,
    output logic               wake
);

    typedef enum logic {
        IDLE,
        DISPATCH
    } state_t;

    // Unimplemented IF bits read back as 1, like the original hardware.
    localparam logic [7:0] LOW_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);
    localparam logic [7:0] PAD_ONES = ~LOW_MASK;

    state_t             state_q;
    state_t             state_n;
    logic [7:0]         ie_r;
    logic [NUM_IRQ-1:0] if_r;
    logic [NUM_IRQ-1:0] if_n;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] pending;
    logic               ime_r;
    logic               ime_n;
    logic               ei_pend_r;
    logic               ei_pend_n;
    logic [2:0]         idx_r;
    logic [2:0]         idx_n;
    logic [7:0]         vec_r;
    logic               dispatch;
    logic               ack_hit;

    function automatic logic [7:0] vec_of(input logic [2:0] i);
        return 8'(int'(VEC_BASE) + int'(i) * VEC_STRIDE);
    endfunction

    assign pending  = ie_r[NUM_IRQ-1:0] & if_r;
    assign dispatch = (state_q == IDLE) && instr_boundary && ime_r
                      && (|pending);
    assign ack_hit  = (state_q == DISPATCH) && isr_ack;

    // Lowest set bit wins: scan downward so bit 0 is written last.
    always_comb begin
        idx_n = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) idx_n = 3'(i);
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:     if (dispatch) state_n = DISPATCH;
            DISPATCH: if (isr_ack)  state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // The dispatch check above sees the old IME, so an EI promoted on this
    // boundary cannot dispatch before the following instruction runs.
    always_comb begin
        ime_n     = ime_r;
        ei_pend_n = ei_pend_r;
        if (di) begin
            ime_n     = 1'b0;
            ei_pend_n = 1'b0;
        end else if (state_q == DISPATCH) begin
            ime_n     = ime_r;
            ei_pend_n = ei_pend_r;
        end else if (dispatch) begin
            ime_n     = 1'b0;
            ei_pend_n = 1'b0;
        end else begin
            if (reti) ime_n = 1'b1;
            if (ei && !ime_r) ei_pend_n = 1'b1;
            if (instr_boundary && ei_pend_r) begin
                ime_n     = 1'b1;
                ei_pend_n = 1'b0;
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = ack_hit && (idx_r == 3'(i));
        end
    end

    // Write, then ack clear, then request set: a new request never gets lost.
    always_comb begin
        if_n = if_wr ? wdata[NUM_IRQ-1:0] : if_r;
        if_n = if_n & ~clr_mask;
        if_n = if_n | irq_pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ie_r      <= '0;
            if_r      <= '0;
            ime_r     <= 1'b0;
            ei_pend_r <= 1'b0;
            idx_r     <= '0;
            vec_r     <= VEC_BASE;
        end else begin
            state_q   <= state_n;
            if (ie_wr) ie_r <= wdata;
            if_r      <= if_n;
            ime_r     <= ime_n;
            ei_pend_r <= ei_pend_n;
            if (dispatch) begin
                idx_r <= idx_n;
                vec_r <= vec_of(idx_n);
            end
        end
    end

    assign isr_cmd    = (state_q == DISPATCH);
    assign isr_vector = vec_r;
    assign ime_q      = ime_r;
    assign ie_q       = ie_r;
    assign if_q       = PAD_ONES | 8'(if_r);
    assign wake       = |pending;

endmodule
